cpu_sequencer: RTL and testbench



---
 rtl/cpu_pkg.sv | 55 +++++
 rtl/cpu_alu.sv | 34 +++
 rtl/cpu_sequencer.sv | 171 +++++++++++++++++
 tb/tb_cpu_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and encodings for the 8CPU multi-cycle sequencer.
package cpu_pkg;

   typedef enum logic [2:0] {
      S_FETCH_LO,
      S_FETCH_HI,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_HALT
   } state_t;

   localparam logic [3:0] CLS_ALU   = 4'd0;
   localparam logic [3:0] CLS_MOVE  = 4'd1;
   localparam logic [3:0] CLS_MOVEI = 4'd2;
   localparam logic [3:0] CLS_JUMP  = 4'd4;
   localparam logic [3:0] CLS_HALT  = 4'd15;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_NOT = 4'd5;
   localparam logic [3:0] OP_CMP = 4'd6;

   localparam logic [3:0] MV_REG   = 4'd0;
   localparam logic [3:0] MV_LOAD  = 4'd1;
   localparam logic [3:0] MV_STORE = 4'd2;

   localparam logic [3:0] JC_ALWAYS = 4'd0;
   localparam logic [3:0] JC_EQ     = 4'd1;
   localparam logic [3:0] JC_NE     = 4'd2;
   localparam logic [3:0] JC_GRT    = 4'd3;

   localparam int EQ_BIT  = 0;
   localparam int GRT_BIT = 1;

   localparam logic [3:0] PTR_HI = 4'd14;
   localparam logic [3:0] PTR_LO = 4'd15;

   function automatic logic is_legal(input logic [15:0] w);
      logic [3:0] s;
      s = w[11:8];
      case (w[15:12])
         CLS_ALU:   is_legal = (s <= OP_CMP);
         CLS_MOVE:  is_legal = (s <= MV_STORE);
         CLS_MOVEI: is_legal = 1'b1;
         CLS_JUMP:  is_legal = (s <= JC_GRT);
         CLS_HALT:  is_legal = 1'b1;
         default:   is_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU; only CMP produces new flags, other ops pass them through.
module cpu_alu
   import cpu_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [3:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [7:0]        flags,
   output logic [DATA_W-1:0] result,
   output logic [7:0]        flags_new
);

   always_comb begin
      result    = a;
      flags_new = flags;
      case (op)
         OP_ADD: result = a + b;
         OP_SUB: result = a - b;
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_XOR: result = a ^ b;
         OP_NOT: result = ~a;
         OP_CMP: begin
            flags_new          = '0;
            flags_new[EQ_BIT]  = (a == b);
            flags_new[GRT_BIT] = (a > b);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute control unit with req/ack memory port.
// Define CPU_STEP_EN to add a single-step input gating each instruction fetch.
module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter int                DATA_W   = 8,
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_IP = '0
) (
`ifdef CPU_STEP_EN
   input  logic              step,
`endif
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [7:0]        flags,
   output logic [ADDR_W-1:0] ip,
   output logic              halted,
   output logic              illegal
);

   state_t            state;
   logic [15:0]       instr;
   logic [DATA_W-1:0] regs [16];
   logic [3:0]        cls, sub, rd, rs;
   logic [DATA_W-1:0] rd_val, rs_val, alu_res;
   logic [7:0]        alu_flags;
   logic [ADDR_W-1:0] ptr, ip_inc, ip_jmp;
   logic              is_mem, taken, fetch_go;

   assign cls    = instr[15:12];
   assign sub    = instr[11:8];
   assign rd     = instr[7:4];
   assign rs     = instr[3:0];
   assign rd_val = regs[rd];
   assign rs_val = regs[rs];
   assign ptr    = ADDR_W'({regs[PTR_HI], regs[PTR_LO]});
   assign ip_inc = ip + ADDR_W'(2);
   assign ip_jmp = ip + (ADDR_W'($signed(instr[7:0])) << 1);
   assign is_mem = (cls == CLS_MOVE) && (sub == MV_LOAD || sub == MV_STORE);

`ifdef CPU_STEP_EN
   logic armed;
   assign fetch_go = armed;
`else
   assign fetch_go = 1'b1;
`endif

   cpu_alu #(.DATA_W(DATA_W)) u_alu (
      .op        (sub),
      .a         (rd_val),
      .b         (rs_val),
      .flags     (flags),
      .result    (alu_res),
      .flags_new (alu_flags)
   );

   always_comb begin
      taken = 1'b0;
      case (sub)
         JC_ALWAYS: taken = 1'b1;
         JC_EQ:     taken = flags[EQ_BIT];
         JC_NE:     taken = !flags[EQ_BIT];
         JC_GRT:    taken = flags[GRT_BIT];
         default:   taken = 1'b0;
      endcase
   end

   // Memory port is a pure function of state and registers, never of ack.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = ip;
      mem_wdata = rd_val;
      if (!rst) begin
         case (state)
            S_FETCH_LO: mem_req = fetch_go;
            S_FETCH_HI: begin
               mem_req  = 1'b1;
               mem_addr = ip + ADDR_W'(1);
            end
            S_MEM: begin
               mem_req  = 1'b1;
               mem_we   = (sub == MV_STORE);
               mem_addr = ptr;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_FETCH_LO;
         ip      <= RESET_IP;
         instr   <= '0;
         flags   <= '0;
         halted  <= 1'b0;
         illegal <= 1'b0;
         for (int i = 0; i < 16; i++) regs[i] <= '0;
`ifdef CPU_STEP_EN
         armed   <= 1'b0;
`endif
      end else begin
         illegal <= 1'b0;
         unique case (state)
            S_FETCH_LO: begin
`ifdef CPU_STEP_EN
               armed <= armed ? !mem_ack : step;
`endif
               if (fetch_go && mem_ack) begin
                  instr[7:0] <= mem_rdata[7:0];
                  state      <= S_FETCH_HI;
               end
            end
            S_FETCH_HI: begin
               if (mem_ack) begin
                  instr[15:8] <= mem_rdata[7:0];
                  state       <= S_DECODE;
               end
            end
            S_DECODE: begin
               unique case (1'b1)
                  !is_legal(instr): begin
                     illegal <= 1'b1;
                     state   <= S_EXEC;
                  end
                  cls == CLS_HALT: begin
                     halted <= 1'b1;
                     state  <= S_HALT;
                  end
                  is_mem:  state <= S_MEM;
                  default: state <= S_EXEC;
               endcase
            end
            S_EXEC: begin
               ip    <= ip_inc;
               state <= S_FETCH_LO;
               // The illegal pulse doubles as the NOP gate here.
               if (!illegal) begin
                  case (cls)
                     CLS_ALU: begin
                        flags <= alu_flags;
                        if (sub != OP_CMP) regs[rd] <= alu_res;
                     end
                     CLS_MOVE:  regs[rd] <= rs_val;
                     CLS_MOVEI: regs[sub] <= DATA_W'(instr[7:0]);
                     CLS_JUMP:  if (taken) ip <= ip_jmp;
                     default: ;
                  endcase
               end
            end
            S_MEM: begin
               if (mem_ack) begin
                  if (sub == MV_LOAD) regs[rd] <= mem_rdata;
                  ip    <= ip_inc;
                  state <= S_FETCH_LO;
               end
            end
            S_HALT: state <= S_HALT;
            default: state <= S_FETCH_LO;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed and random programs against an ISA-level interpreter.
module tb_cpu_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_req, mem_we, halted, illegal;
   logic        mem_ack = 1'b0;
   logic [15:0] mem_addr, ip;
   logic [7:0]  mem_wdata, flags;
   logic [7:0]  mem_rdata = 8'h00;

   cpu_sequencer #(
      .DATA_W   (8),
      .ADDR_W   (16),
      .RESET_IP (16'h0000)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .flags     (flags),
      .ip        (ip),
      .halted    (halted),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   logic [7:0]  mem   [65536];
   logic [7:0]  m_mem [65536];
   logic [15:0] prog  [$];
   int          fixed_wait = 0;
   int          max_wait = 0;
   int          wait_left = 0;
   int          req_cycles = 0;
   int          store_cycles = 0;
   int          illegal_cycles = 0;
   bit          hold = 0;
   bit          wr_pend = 0;
   logic [15:0] h_addr, wr_addr;
   logic [7:0]  h_wdata, wr_data;
   logic        h_we;

   function automatic int new_wait();
      return (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, max_wait));
   endfunction

   // Memory responder: decides ack on the falling edge, commits writes one edge later.
   always @(negedge clk) begin
      if (wr_pend) begin
         mem[wr_addr] = wr_data;
         wr_pend = 0;
      end
      mem_rdata = 8'($urandom);
      if (illegal) illegal_cycles++;
      if (rst) begin
         mem_ack = 1'b0;
         hold = 0;
         wait_left = new_wait();
      end else if (mem_req) begin
         req_cycles++;
         if (mem_we) store_cycles++;
         if (hold) begin
            check("hold_addr", mem_addr, h_addr);
            check("hold_we", mem_we, h_we);
            check("hold_wdata", mem_wdata, h_wdata);
         end
         if (wait_left == 0) begin
            mem_ack = 1'b1;
            hold = 0;
            if (mem_we) begin
               wr_pend = 1;
               wr_addr = mem_addr;
               wr_data = mem_wdata;
            end else begin
               mem_rdata = mem[mem_addr];
            end
            wait_left = new_wait();
         end else begin
            mem_ack = 1'b0;
            hold = 1;
            h_addr = mem_addr;
            h_we = mem_we;
            h_wdata = mem_wdata;
            wait_left--;
         end
      end else begin
         if (hold) check("req_held", mem_req, 1);
         mem_ack = 1'b0;
         hold = 0;
      end
   end

   logic [7:0]  m_reg [16];
   logic [7:0]  m_flags;
   logic [15:0] m_ip;
   bit          m_halt;
   int          m_ill;

   task automatic model_run();
      logic [15:0] w, nxt;
      logic [3:0]  c, s, d, r;
      logic [7:0]  a, b;
      bit          tk;
      for (int i = 0; i < 16; i++) m_reg[i] = 8'h00;
      m_flags = 8'h00;
      m_ip = 16'h0000;
      m_halt = 0;
      m_ill = 0;
      for (int n = 0; n < 5000 && !m_halt; n++) begin
         w = {m_mem[m_ip + 16'd1], m_mem[m_ip]};
         c = w[15:12];
         s = w[11:8];
         d = w[7:4];
         r = w[3:0];
         a = m_reg[d];
         b = m_reg[r];
         nxt = m_ip + 16'd2;
         case (c)
            4'd0: case (s)
               4'd0: m_reg[d] = a + b;
               4'd1: m_reg[d] = a - b;
               4'd2: m_reg[d] = a & b;
               4'd3: m_reg[d] = a | b;
               4'd4: m_reg[d] = a ^ b;
               4'd5: m_reg[d] = ~a;
               4'd6: m_flags = {6'd0, a > b, a == b};
               default: m_ill++;
            endcase
            4'd1: case (s)
               4'd0: m_reg[d] = b;
               4'd1: m_reg[d] = m_mem[{m_reg[14], m_reg[15]}];
               4'd2: m_mem[{m_reg[14], m_reg[15]}] = a;
               default: m_ill++;
            endcase
            4'd2: m_reg[s] = w[7:0];
            4'd4: begin
               case (s)
                  4'd0: tk = 1;
                  4'd1: tk = m_flags[0];
                  4'd2: tk = !m_flags[0];
                  4'd3: tk = m_flags[1];
                  default: begin
                     tk = 0;
                     m_ill++;
                  end
               endcase
               if (tk) nxt = m_ip + ({{8{w[7]}}, w[7:0]} << 1);
            end
            4'd15: begin
               m_halt = 1;
               nxt = m_ip;
            end
            default: m_ill++;
         endcase
         m_ip = nxt;
      end
   endtask

   task automatic load_prog();
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < prog.size(); i++) begin
         mem[16'(2 * i)]     = prog[i][7:0];
         mem[16'(2 * i + 1)] = prog[i][15:8];
      end
      for (int i = 0; i < 65536; i++) m_mem[i] = mem[i];
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_ip", ip, 16'h0000);
      check("rst_flags", flags, 8'h00);
      check("rst_halted", halted, 0);
      check("rst_illegal", illegal, 0);
      check("rst_req", mem_req, 0);
      illegal_cycles = 0;
      store_cycles = 0;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic wait_halt();
      bit ok = 0;
      for (int c = 0; c < 20000; c++) begin
         @(negedge clk);
         if (halted) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check("halt_timeout", halted, 1);
   endtask

   task automatic gen_random();
      int          k;
      logic [3:0]  rd, rs;
      logic [7:0]  imm;
      prog = '{16'h2E90};
      for (int i = 0; i < 24; i++) begin
         k = int'($urandom_range(0, 9));
         rd = 4'($urandom_range(0, 13));
         rs = 4'($urandom_range(0, 15));
         imm = 8'($urandom);
         case (k)
            0, 1, 2: prog.push_back({4'h0, 4'($urandom_range(0, 7)), rd, rs});
            3: prog.push_back({8'h10, rd, rs});
            4: prog.push_back({8'h11, rd, rs});
            5: prog.push_back({8'h12, rs, 4'h0});
            6: prog.push_back({4'h2, rd, imm});
            7: if ($urandom_range(0, 1) == 1) prog.push_back({8'h2E, 2'b10, imm[5:0]});
               else prog.push_back({8'h2F, imm});
            8: prog.push_back({4'h4, 4'($urandom_range(0, 4)), 8'($urandom_range(1, 3))});
            default: prog.push_back({($urandom_range(0, 1) == 1) ? 4'h3
                                     : 4'($urandom_range(5, 14)), 12'($urandom)});
         endcase
      end
      prog.push_back(16'h2EF0);
      for (int i = 0; i < 14; i++) begin
         prog.push_back({8'h2F, 8'(i)});
         prog.push_back({8'h12, 4'(i), 4'h0});
      end
      prog.push_back(16'hF000);
   endtask

   initial begin
      int r0, diffs;
      bit found;

      // ADD after two MOVEIs, zero-wait latency
      fixed_wait = 0;
      prog = '{16'h2105, 16'h2203, 16'h0012, 16'h2EF0, 16'h2F01, 16'h1210, 16'hF000};
      load_prog();
      do_reset();
      repeat (11) @(posedge clk);
      #1 check("lat_ip_c11", ip, 16'h0004);
      @(posedge clk);
      #1 check("lat_ip_c12", ip, 16'h0006);
      wait_halt();
      check("add_r1", mem[16'hF001], 8'h08);
      check("add_ip", ip, 16'h000C);

      // wrapping ADD leaves flags alone
      prog = '{16'h21FF, 16'h2201, 16'h0012, 16'h2EF0, 16'h2F02, 16'h1210, 16'hF000};
      load_prog();
      do_reset();
      wait_halt();
      check("wrap_r1", mem[16'hF002], 8'h00);
      check("wrap_flags", flags, 8'h00);

      prog = '{16'h21FF, 16'h2201, 16'h0012, 16'h0611,
               16'h2EF0, 16'h2F02, 16'h1210, 16'hF000};
      load_prog();
      do_reset();
      wait_halt();
      check("cmp_eq_flags", flags, 8'h01);

      // store through {r14,r15} with waits
      fixed_wait = 2;
      prog = '{16'h2E12, 16'h2F34, 16'h23AA, 16'h1230, 16'hF000};
      load_prog();
      do_reset();
      wait_halt();
      check("store_mem", mem[16'h1234], 8'hAA);
      check("store_req_cycles", store_cycles, 3);

      // conditional jumps
      fixed_wait = 0;
      prog = '{16'h2105, 16'h2203, 16'h0612, 16'h4005, 16'hF000,
               16'hF000, 16'hF000, 16'hF000, 16'h43FE, 16'hF000};
      load_prog();
      do_reset();
      wait_halt();
      check("jgrt_ip", ip, 16'h000C);
      check("jgrt_flags", flags, 8'h02);
      prog[8] = 16'h41FE;
      load_prog();
      do_reset();
      wait_halt();
      check("jeq_ip", ip, 16'h0012);

      // illegal encodings then HALT
      prog = '{16'h3000, 16'h0700, 16'h1300, 16'h4400, 16'hF000};
      load_prog();
      do_reset();
      wait_halt();
      check("ill_pulses", illegal_cycles, 4);
      check("ill_ip", ip, 16'h0008);
      r0 = req_cycles;
      repeat (10) @(negedge clk);
      check("halt_noreq", req_cycles - r0, 0);
      check("halt_sticky", halted, 1);

      // reset in the middle of FETCH_HI
      fixed_wait = 3;
      prog = '{16'h2105, 16'h2203, 16'h0012, 16'h2EF0, 16'h2F01, 16'h1210, 16'hF000};
      load_prog();
      do_reset();
      found = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (mem_req && mem_addr == 16'h0005) begin
            found = 1;
            break;
         end
      end
      check("midrst_seen", found, 1);
      @(posedge clk);
      #1 rst = 1'b1;
      #1 check("midrst_req", mem_req, 0);
      @(posedge clk);
      #1 check("midrst_ip", ip, 16'h0000);
      check("midrst_halted", halted, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      wait_halt();
      check("midrst_r1", mem[16'hF001], 8'h08);
      check("midrst_end_ip", ip, 16'h000C);

      // random programs
      fixed_wait = -1;
      max_wait = 3;
      for (int t = 0; t < 6; t++) begin
         gen_random();
         load_prog();
         model_run();
         do_reset();
         wait_halt();
         diffs = 0;
         for (int i = 0; i < 65536; i++) if (mem[i] !== m_mem[i]) diffs++;
         check("rand_mem", diffs, 0);
         check("rand_ip", ip, m_ip);
         check("rand_flags", flags, m_flags);
         check("rand_halted", halted, m_halt);
         check("rand_illegal", illegal_cycles, m_ill);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
